full_substractor: RTL and testbench

Registered full subtractor: computes `a - b - B_in` and presents the difference and the borrow-out on clocked outputs. The datapath is a ripple chain of 1-bit full-subtractor cells, so the same block serves as the 1-bit cell (`WIDTH=1`, the default) and as a multi-bit subtractor. It is a leaf arithmetic block for datapaths that need a synchronous subtract with borrow in and out.

---
 rtl/full_substractor.sv | 64 ++++++
 tb/tb_full_substractor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/full_substractor.sv
// Registered full subtractor: diff/borrow = a - b - B_in, built as a ripple
// chain of 1-bit full-subtractor cells feeding a single output register stage.
module full_substractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             B_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             out_valid
);

  // One full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fs_cell(input logic a_bit, input logic b_bit,
                                         input logic bin);
    logic d_bit;
    logic bout;
    d_bit  = a_bit ^ b_bit ^ bin;
    bout   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
    fs_cell = {bout, d_bit};
  endfunction

  logic [WIDTH:0]   borrow_chain;
  logic [WIDTH-1:0] diff_chain;

  logic [WIDTH-1:0] diff_p0;
  logic             borrow_p0;
  logic             vld_p0;

  // Ripple the borrow from the LSB cell (seeded by B_in) up to the MSB cell.
  always_comb begin
    borrow_chain    = '0;
    diff_chain      = '0;
    borrow_chain[0] = B_in;
    for (int i = 0; i < WIDTH; i++) begin
      {borrow_chain[i+1], diff_chain[i]} = fs_cell(a[i], b[i], borrow_chain[i]);
    end
  end

  // Stage p0: capture the chain result on a valid edge, otherwise hold it;
  // the valid flag is a one-cycle pulse per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_p0   <= '0;
      borrow_p0 <= 1'b0;
      vld_p0    <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        diff_p0   <= diff_chain;
        borrow_p0 <= borrow_chain[WIDTH];
      end
    end
  end

  assign diff      = diff_p0;
  assign borrow    = borrow_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_full_substractor.sv
`timescale 1ns/1ps
// Self-checking bench for full_substractor at WIDTH = 1, 8 and 16.
module tb_full_substractor;

  logic clk;
  logic rst_n;

  logic       a1, b1, bin1, v1;
  logic       d1, br1, ov1;
  logic [7:0] a8, b8, d8;
  logic       bin8, v8, br8, ov8;
  logic [15:0] a16, b16, d16;
  logic        bin16, v16, br16, ov16;

  int tests;
  int fails;

  full_substractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .B_in(bin1), .in_valid(v1),
    .diff(d1), .borrow(br1), .out_valid(ov1)
  );

  full_substractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .B_in(bin8), .in_valid(v8),
    .diff(d8), .borrow(br8), .out_valid(ov8)
  );

  full_substractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .B_in(bin16), .in_valid(v16),
    .diff(d16), .borrow(br16), .out_valid(ov16)
  );

  // 100 ns clock period.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden 16-bit model: {borrow, diff} = a - b - B_in in 17-bit arithmetic.
  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic bin);
    ref16 = {1'b0, a} - {1'b0, b} - 17'(bin);
  endfunction

  // Truth table for the 1-bit cell, indexed by {a, b, B_in}: {diff, borrow}.
  logic [1:0] tt [8];

  logic [16:0] r17;
  logic [15:0] exp_d16;
  logic        exp_b16;
  logic [2:0]  vec;

  initial begin
    tests = 0;
    fails = 0;
    tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b01;
    tt[4] = 2'b10; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;

    // Reset with unknown inputs.
    rst_n = 1'b0;
    a1 = 'x; b1 = 'x; bin1 = 'x; v1 = 'x;
    a8 = 'x; b8 = 'x; bin8 = 'x; v8 = 'x;
    a16 = 'x; b16 = 'x; bin16 = 'x; v16 = 'x;
    #30;
    chk("rst_d1", 64'(d1), 64'd0);
    chk("rst_br1", 64'(br1), 64'd0);
    chk("rst_ov1", 64'(ov1), 64'd0);
    chk("rst_d8", 64'(d8), 64'd0);
    chk("rst_d16", 64'(d16), 64'd0);
    tick();
    chk("rst_hold_d1", 64'(d1), 64'd0);
    chk("rst_hold_ov1", 64'(ov1), 64'd0);
    chk("rst_hold_br16", 64'(br16), 64'd0);
    v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    #20;
    rst_n = 1'b1;
    tick();

    // Exhaustive 1-bit truth table.
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      {a1, b1, bin1} = vec;
      v1 = 1'b1;
      tick();
      chk($sformatf("tt%0d_diff", i), 64'(d1), 64'(tt[i][1]));
      chk($sformatf("tt%0d_borrow", i), 64'(br1), 64'(tt[i][0]));
      chk($sformatf("tt%0d_ov", i), 64'(ov1), 64'd1);
    end

    // Hold: capture 1-0-0, then toggle inputs with in_valid low.
    a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0; v1 = 1'b1;
    tick();
    chk("hold_cap_diff", 64'(d1), 64'd1);
    chk("hold_cap_borrow", 64'(br1), 64'd0);
    v1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a1 = ~a1; b1 = ~b1; bin1 = 1'($urandom);
      tick();
      chk($sformatf("hold%0d_diff", i), 64'(d1), 64'd1);
      chk($sformatf("hold%0d_borrow", i), 64'(br1), 64'd0);
      chk($sformatf("hold%0d_ov", i), 64'(ov1), 64'd0);
    end

    // 8-bit wrap cases.
    a8 = 8'h05; b8 = 8'h07; bin8 = 1'b1; v8 = 1'b1;
    tick();
    chk("w8_wrap_diff", 64'(d8), 64'hFD);
    chk("w8_wrap_borrow", 64'(br8), 64'd1);
    chk("w8_wrap_ov", 64'(ov8), 64'd1);
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
    tick();
    chk("w8_max_diff", 64'(d8), 64'hFF);
    chk("w8_max_borrow", 64'(br8), 64'd0);
    v8 = 1'b0;
    tick();
    chk("w8_ov_drop", 64'(ov8), 64'd0);
    chk("w8_hold_diff", 64'(d8), 64'hFF);

    // Reset mid-stream with in_valid held high.
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
    v16 = 1'b1; a16 = 16'h1234; b16 = 16'h0034; bin16 = 1'b0;
    tick();
    chk("mid_pre_d1", 64'(d1), 64'd1);
    chk("mid_pre_d16", 64'(d16), 64'h1200);
    #20;
    rst_n = 1'b0;
    #1;
    chk("async_clr_d1", 64'(d1), 64'd0);
    chk("async_clr_ov1", 64'(ov1), 64'd0);
    chk("async_clr_d16", 64'(d16), 64'd0);
    chk("async_clr_ov16", 64'(ov16), 64'd0);
    a1 = 1'b1; b1 = 1'b1; bin1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("mid_rst%0d_diff", i), 64'(d1), 64'd0);
      chk($sformatf("mid_rst%0d_borrow", i), 64'(br1), 64'd0);
      chk($sformatf("mid_rst%0d_ov", i), 64'(ov1), 64'd0);
    end
    #20;
    rst_n = 1'b1;
    tick();
    chk("post_rst_diff", 64'(d1), 64'd1);
    chk("post_rst_borrow", 64'(br1), 64'd1);
    chk("post_rst_ov", 64'(ov1), 64'd1);
    v1 = 1'b0;

    // Random 16-bit regression with occasional idle cycles.
    exp_d16 = d16;
    exp_b16 = br16;
    for (int i = 0; i < 10000; i++) begin
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      bin16 = 1'($urandom);
      v16   = ($urandom_range(0, 7) != 0);
      if (v16) begin
        r17 = ref16(a16, b16, bin16);
        exp_d16 = r17[15:0];
        exp_b16 = r17[16];
      end
      tick();
      chk("rnd_diff", 64'(d16), 64'(exp_d16));
      chk("rnd_borrow", 64'(br16), 64'(exp_b16));
      chk("rnd_ov", 64'(ov16), 64'(v16));
    end
    v16 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
